// File: rtl/reg_bank_pkg.sv
// Shared widths and types for the 32 x 32-bit general-purpose register bank.
package reg_bank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_bank_read_port.sv
// Combinational DEPTH:1 read mux over the flattened register array.
module reg_bank_read_port
    import reg_bank_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DEPTH  = DEPTH
) (
    input  logic [P_DEPTH-1:0][P_DATA_W-1:0] regs_i,
    input  logic [P_ADDR_W-1:0]              addr_i,
    output logic [P_DATA_W-1:0]              data_o
);

    assign data_o = regs_i[addr_i];

endmodule

// File: rtl/reg_bank_32x32_rst.sv
// Register bank: 2 combinational read ports, 1 write port, synchronous clear.
// Optional REG_ZERO_HARDWIRED_EN makes register 0 read as constant zero.
module reg_bank_32x32_rst
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W,
    parameter int DEPTH  = reg_bank_pkg::DEPTH
) (
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    input  logic [ADDR_W-1:0] dr,
    input  logic              write,
    input  logic              clk,
    input  logic              reset
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[dr] = wrData;
        end
`ifdef REG_ZERO_HARDWIRED_EN
        // Constant zero lets synthesis drop the register 0 flops entirely.
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_bank_read_port #(
        .P_DATA_W(DATA_W),
        .P_ADDR_W(ADDR_W),
        .P_DEPTH (DEPTH)
    ) u_rd_port1 (
        .regs_i(regs_q),
        .addr_i(sr1),
        .data_o(rdData1)
    );

    reg_bank_read_port #(
        .P_DATA_W(DATA_W),
        .P_ADDR_W(ADDR_W),
        .P_DEPTH (DEPTH)
    ) u_rd_port2 (
        .regs_i(regs_q),
        .addr_i(sr2),
        .data_o(rdData2)
    );

endmodule

// File: tb/tb_reg_bank_32x32_rst.sv
// Directed bench for reg_bank_32x32_rst: array model checked every cycle plus literal pins.
module tb_reg_bank_32x32_rst;

    logic [31:0] rdData1;
    logic [31:0] rdData2;
    logic [31:0] wrData;
    logic [4:0]  sr1;
    logic [4:0]  sr2;
    logic [4:0]  dr;
    logic        write;
    logic        clk;
    logic        reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];
    bit          mdl_valid = 0;

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit HARDWIRED = 1'b1;
`else
    localparam bit HARDWIRED = 1'b0;
`endif

    reg_bank_32x32_rst dut (
        .rdData1(rdData1),
        .rdData2(rdData2),
        .wrData (wrData),
        .sr1    (sr1),
        .sr2    (sr2),
        .dr     (dr),
        .write  (write),
        .clk    (clk),
        .reset  (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (HARDWIRED && a == 5'd0) return 32'h0;
        return mdl[a];
    endfunction

    // Model follows the register-file rules directly: clear wins, else one write.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mdl_valid = 1;
        end else if (write && !(HARDWIRED && dr == 5'd0)) begin
            mdl[dr] = wrData;
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            chk("model_rd1", rdData1, mdl_read(sr1));
            chk("model_rd2", rdData2, mdl_read(sr2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        write  = 1'b0;
        dr     = '0;
        wrData = '0;
        sr1    = '0;
        sr2    = '0;
        step();
        reset = 1'b0;
        #1;
        chk("reset_state_rd1", rdData1, 32'h0);
        chk("reset_state_rd2", rdData2, 32'h0);

        // Preload then clear
        write = 1'b1; dr = 5'd5; wrData = 32'hDEADBEEF;
        step();
        write = 1'b0; sr1 = 5'd5;
        #1 chk("preload_r5", rdData1, 32'hDEADBEEF);
        reset = 1'b1;
        step();
        reset = 1'b0; sr1 = 5'd5; sr2 = 5'd31;
        #1;
        chk("reset_r5", rdData1, 32'h0);
        chk("reset_r31", rdData2, 32'h0);

        // Fill register k with k
        for (int k = 0; k < 32; k++) begin
            write = 1'b1; dr = 5'(k); wrData = 32'(k);
            step();
        end
        write = 1'b0;
        for (int k = 0; k < 32; k += 2) begin
            sr1 = 5'(k); sr2 = 5'(k + 1);
            #1;
            chk("fill_rd1", rdData1, 32'(k));
            chk("fill_rd2", rdData2, 32'(k + 1));
            step();
        end

        // Write disabled
        write = 1'b0; dr = 5'd7; wrData = 32'h12345678;
        step();
        sr1 = 5'd7; sr2 = 5'd7;
        #1;
        chk("wdis_rd1", rdData1, 32'd7);
        chk("wdis_rd2", rdData2, 32'd7);

        // Read during write: old value before edge, new after
        sr1 = 5'd3; write = 1'b1; dr = 5'd3; wrData = 32'hA5A5A5A5;
        #1 chk("rdw_before", rdData1, 32'd3);
        step();
        write = 1'b0;
        #1 chk("rdw_after", rdData1, 32'hA5A5A5A5);

        // Reset pulse between edges does nothing
        reset = 1'b1;
        #1 chk("midcycle_reset", rdData1, 32'hA5A5A5A5);
        reset = 1'b0;
        step();
        chk("midcycle_reset_hold", rdData1, 32'hA5A5A5A5);

        // Back-to-back writes to the same then a different register
        write = 1'b1; dr = 5'd10; wrData = 32'h0000_1111;
        step();
        dr = 5'd10; wrData = 32'h0000_2222;
        step();
        dr = 5'd11; wrData = 32'h0000_3333;
        step();
        write = 1'b0; sr1 = 5'd10; sr2 = 5'd11;
        #1;
        chk("b2b_r10", rdData1, 32'h0000_2222);
        chk("b2b_r11", rdData2, 32'h0000_3333);

        // Register 0 write
        write = 1'b1; dr = 5'd0; wrData = 32'h55;
        step();
        write = 1'b0; sr1 = 5'd0; sr2 = 5'd0;
        #1;
        chk("r0_rd1", rdData1, HARDWIRED ? 32'h0 : 32'h55);
        chk("r0_rd2", rdData2, HARDWIRED ? 32'h0 : 32'h55);

        // Reset priority over simultaneous write
        sr1 = 5'd9;
        #1 chk("pri_before", rdData1, 32'd9);
        reset = 1'b1; write = 1'b1; dr = 5'd9; wrData = 32'hFFFFFFFF;
        step();
        reset = 1'b0; write = 1'b0;
        #1 chk("pri_r9", rdData1, 32'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
